// File: rtl/sclsu.sv
// Load/store unit between the single-cycle MIPS datapath and a word-only,
// registered-read data RAM; sub-word stores use read-modify-write, big-endian lanes.
module sclsu #(
    parameter int AW     = 5,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_we,
    input  logic [31:0]   mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic           wr_q, wr_d;
    logic [1:0]     size_q, size_d;
    logic           sext_q, sext_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    merge_q, merge_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           err_q, err_d;

    logic           misaligned;
    logic [7:0]     byte_lane;
    logic [15:0]    half_lane;
    logic [31:0]    load_val;
    logic [31:0]    merged;
    logic           addr_unused;

    // Only the word-address bits reach the RAM; the rest of the byte address is dropped.
    assign addr_unused = ^addr[31:AW+2];

    assign misaligned = ((size == 2'b01) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));

    always_comb begin
        byte_lane = mem_dout[31:24];
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_dout[31:24];
            2'd1:    byte_lane = mem_dout[23:16];
            2'd2:    byte_lane = mem_dout[15:8];
            default: byte_lane = mem_dout[7:0];
        endcase
        half_lane = addr_q[1] ? mem_dout[15:0] : mem_dout[31:16];

        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{sext_q & half_lane[15]}}, half_lane};
            default: load_val = mem_dout;
        endcase

        merged = mem_dout;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
            else           merged[31:16] = wdata_q[15:0];
        end
    end

    // Handshake: a request is taken only on an edge where req=1 and ready=1;
    // req while busy is dropped, and done pulses for exactly one cycle per accepted request.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    sext_d  = sext;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (wr && size[1]) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = 3'(RD_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (wr_q) begin
                        merge_d = merged;
                        state_d = S_WRITE;
                    end else begin
                        rdata_d = load_val;
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state register so reset kills mem_we at once.
    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign mem_we   = (state_q == S_WRITE);
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign mem_addr = addr_q[AW+1:2];
    assign mem_din  = size_q[1] ? wdata_q : merge_q;

endmodule

// File: tb/tb_sclsu.sv
// Bench for sclsu: three instances (RD_LAT 1..3), each on its own RAM model,
// checked against a word-array reference of memory and load results.
module tb_sclsu;
    localparam int NI = 3;
    localparam int AW = 5;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    logic          req_v   [NI];
    logic          wr, sext;
    logic [1:0]    size;
    logic [31:0]   addr, wdata;
    logic          ready_v [NI];
    logic          done_v  [NI];
    logic          err_v   [NI];
    logic          we_v    [NI];
    logic [31:0]   rdata_v [NI];
    logic [31:0]   din_v   [NI];
    logic [31:0]   dout_v  [NI];
    logic [AW-1:0] maddr_v [NI];

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;
    logic [31:0]   ram  [NI][NW];
    logic [31:0]   pipe [NI][NI];

    logic [31:0]   ref_mem   [NI][NW];
    logic [31:0]   ref_rdata [NI];
    int            checks, errors;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sclsu #(.AW(AW), .RD_LAT(g + 1)) u_dut (
            .clk(clk), .clrn(clrn), .req(req_v[g]), .wr(wr), .size(size), .sext(sext),
            .addr(addr), .wdata(wdata), .ready(ready_v[g]), .done(done_v[g]), .err(err_v[g]),
            .rdata(rdata_v[g]), .mem_addr(maddr_v[g]), .mem_din(din_v[g]), .mem_we(we_v[g]),
            .mem_dout(dout_v[g])
        );
    end

    // RAM models: instance i sees read data i+1 edges after the address.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (we_v[i]) ram[i][maddr_v[i]] <= din_v[i];
            else if (pre_we) ram[i][pre_addr] <= pre_data;
            pipe[i][0] <= ram[i][maddr_v[i]];
            for (int k = 1; k < NI; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end
    always_comb for (int i = 0; i < NI; i++) dout_v[i] = pipe[i][i];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 32'h0000_00FF << (24 - 8 * int'(a[1:0]));
        if (sz == 2'b01) return a[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int lane_shift(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 24 - 8 * int'(a[1:0]);
        if (sz == 2'b01) return a[1] ? 0 : 16;
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [31:0] a);
        logic [31:0] v;
        v = (w & lane_mask(sz, a)) >> lane_shift(sz, a);
        if (sz == 2'b00 && sx && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 2'b01 && sx && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        m = lane_mask(sz, a);
        return (old & ~m) | ((wd << lane_shift(sz, a)) & m);
    endfunction

    task automatic preload(input logic [AW-1:0] wa, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = wa; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        for (int i = 0; i < NI; i++) ref_mem[i][wa] = d;
    endtask

    task automatic do_txn(input int i, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int rd, lat, c, we_cnt, dn;
        bit mis, addr_ok, din_ok;
        logic [AW-1:0] wa;
        logic [31:0] exp_din;
        rd  = i + 1;
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        wa  = a[AW+1:2];
        exp_din = exp_merge(ref_mem[i][wa], sz, a, wd);
        if (mis)              lat = 1;
        else if (w && sz[1])  lat = 2;
        else if (w)           lat = 3 + rd;
        else                  lat = 2 + rd;

        @(negedge clk);
        check("ready_before", 32'(ready_v[i]), 1);
        wr = w; size = sz; sext = sx; addr = a; wdata = wd; req_v[i] = 1'b1;
        @(posedge clk); #1;
        if (!hold) req_v[i] = 1'b0;
        c = 1; we_cnt = 0; addr_ok = 1; din_ok = 1;
        while (!done_v[i] && c <= 40) begin
            if (maddr_v[i] !== wa) addr_ok = 0;
            if (we_v[i]) begin
                we_cnt++;
                if (din_v[i] !== exp_din) din_ok = 0;
            end
            @(posedge clk); #1;
            c++;
        end
        req_v[i] = 1'b0;
        if (maddr_v[i] !== wa) addr_ok = 0;
        check("done_latency", 32'(c), 32'(lat));
        check("err", 32'(err_v[i]), 32'(mis));
        check("we_count", 32'(we_cnt), (w && !mis) ? 1 : 0);
        check("addr_stable", 32'(addr_ok), 1);
        check("mem_din", 32'(din_ok), 1);
        if (!w && !mis) ref_rdata[i] = exp_load(ref_mem[i][wa], sz, sx, a);
        if (w && !mis)  ref_mem[i][wa] = exp_din;
        check("rdata", rdata_v[i], ref_rdata[i]);
        @(posedge clk); #1;
        check("done_pulse", 32'(done_v[i]), 0);
        check("ready_after", 32'(ready_v[i]), 1);
        check("err_clear", 32'(err_v[i]), 0);
        check("ram_word", ram[i][wa], ref_mem[i][wa]);
        if (hold) begin
            dn = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (done_v[i]) dn++;
            end
            check("no_second_done", 32'(dn), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ri;
        logic rw, rsx;
        logic [1:0] rsz;
        logic [31:0] old;
        checks = 0; errors = 0;
        clrn = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < NI; i++) begin
            req_v[i] = 1'b0;
            ref_rdata[i] = '0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_ready", 32'(ready_v[i]), 1);
            check("rst_done", 32'(done_v[i]), 0);
            check("rst_err", 32'(err_v[i]), 0);
            check("rst_we", 32'(we_v[i]), 0);
            check("rst_rdata", rdata_v[i], 0);
            check("rst_maddr", 32'(maddr_v[i]), 0);
            check("rst_din", din_v[i], 0);
        end
        for (int w = 0; w < NW; w++) preload(AW'(w), $urandom);
        @(negedge clk);
        clrn = 1'b1;

        // Word store then word load.
        do_txn(1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 0);
        do_txn(1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0);
        // Byte store merge.
        preload(2, 32'h11223344);
        do_txn(1, 1'b1, 2'b00, 1'b0, 32'h0A, 32'h000000AB, 0);
        // Extension cases.
        preload(3, 32'h80F07F01);
        do_txn(1, 1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, 0);
        do_txn(1, 1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, 0);
        do_txn(1, 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 0);
        // Misaligned.
        do_txn(1, 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 0);
        do_txn(1, 1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 0);
        // req held while busy.
        do_txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1);
        // Latency sweep on RD_LAT=1 and RD_LAT=3.
        preload(2, 32'h11223344);
        for (int i = 0; i < NI; i += 2) begin
            do_txn(i, 1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, 0);
            do_txn(i, 1'b1, 2'b00, 1'b0, 32'h0A, 32'h000000AB, 0);
            do_txn(i, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000CAFE, 0);
        end
        // Random traffic on all instances.
        repeat (60) begin
            ri  = $urandom_range(0, NI - 1);
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            rsx = 1'($urandom_range(0, 1));
            do_txn(ri, rw, rsz, rsx, $urandom, $urandom, 0);
        end

        // Reset in the middle of a sub-word store's WAIT phase.
        old = ref_mem[2][5];
        @(negedge clk);
        wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h15; wdata = 32'h0000005A; req_v[2] = 1'b1;
        @(posedge clk); #1;
        req_v[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        clrn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("abort_ready", 32'(ready_v[i]), 1);
            check("abort_we", 32'(we_v[i]), 0);
            check("abort_done", 32'(done_v[i]), 0);
            check("abort_rdata", rdata_v[i], 0);
            ref_rdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_ram", ram[2][5], old);
        do_txn(2, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sclsu.md
# sclsu

Load/store unit for the single-cycle MIPS CPU, sitting directly upstream of the data memory. It takes one load or store request from the datapath at a time and issues word-wide accesses to the registered-read, word-only data RAM. Sub-word stores are handled by read-modify-write. Loaded bytes and halfwords are extracted and sign- or zero-extended. Byte order is big-endian: `addr[1:0]=0` selects bits 31:24.

## Interface
Parameters:
- AW, 5 — word-address width presented to the data memory.
- RD_LAT, 2 — data memory read latency in cycles, counted from the cycle after the address is presented; legal range 1..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- req  in  1  request strobe; sampled only when ready=1.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the byte or halfword is taken from the low bits.
- ready  out  1  1 only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned access; valid with done.
- rdata  out  32  load result; valid with done, held until the next done.
- mem_addr  out  AW  word address, equal to the latched `addr[AW+1:2]`.
- mem_din  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_dout  in  32  read data from memory.

## Operation
- Outputs are decoded from registered state, latched request fields and the merge buffer.
- State IDLE: ready=1, mem_we=0.
  - On req=1, latch wr, size, sext, addr and wdata.
  - Misaligned requests go to DONE with err=1 and make no memory access. A halfword is misaligned when addr[0]=1; a word is misaligned when addr[1:0]≠0.
  - An aligned word store goes to WRITE.
  - Every other aligned request goes to READ.
- State READ: mem_addr is presented and mem_we=0. Load the counter with RD_LAT, then go to WAIT.
- State WAIT: mem_addr is held. The counter decrements each cycle. In the cycle where the counter equals 1, sample mem_dout on the closing edge:
  - Load: write the extracted and extended lane into rdata, then go to DONE.
  - Store: write the merged word into the merge buffer, then go to WRITE. Merge means replacing only the addressed byte or halfword lane with `wdata[7:0]` or `wdata[15:0]`.
- State WRITE: mem_we=1 for exactly one cycle. mem_din is the merged word for sub-word stores, or wdata for word stores. Then go to DONE.
- State DONE: done=1 and ready=0. On the next edge go to IDLE. err is cleared when leaving DONE.
- Lane extraction:
  - Byte k (k = addr[1:0]) is bits [31-8k : 24-8k].
  - Halfword addr[1]=0 is bits 31:16; addr[1]=1 is bits 15:0.
  - A word load passes mem_dout unchanged and ignores sext.
- Stores leave rdata unchanged.
- req asserted while ready=0 is ignored. It is not queued.

## Timing
- Reset (clrn=0, asynchronous):
  - State goes to IDLE, so ready=1.
  - done=0, err=0, mem_we=0, rdata=0, mem_addr=0, mem_din=0, counter=0.
  - Reset asserted mid-access aborts the access immediately. mem_we drops without waiting for an edge, and no partial write completes afterwards.
- Latencies, with request accepted at the edge ending cycle N:
  - Word store: WRITE in N+1, done in N+2.
  - Load: READ in N+1, WAIT in N+2..N+1+RD_LAT, done in N+2+RD_LAT. With RD_LAT=2, done is in N+4.
  - Sub-word store: WRITE in N+2+RD_LAT, done in N+3+RD_LAT.
  - Misaligned: done and err in N+1.
- ready returns in the cycle after done. The minimum back-to-back spacing is 3 cycles for word stores.
- mem_addr is stable from READ or WRITE entry through WRITE exit. mem_we is never high outside WRITE.

## Test plan
- Reset: assert clrn=0 mid-WAIT of a sub-word store → ready=1 and mem_we=0 immediately. The memory word is unchanged. rdata=0.
- Word store, then load:
  - Store addr=0x08, wdata=0xDEADBEEF → mem_we high for one cycle with mem_addr=2, done at N+2.
  - Then load the word at 0x08, RD_LAT=2 → rdata=0xDEADBEEF at N+4.
- Byte store merge: memory word 2 = 0x11223344; store byte addr=0x0A, wdata=0x000000AB → memory word becomes 0x1122AB44, done at N+5.
- Extension, with memory word 3 = 0x80F0_7F01:
  - Signed byte load at 0x0C → 0xFFFFFF80.
  - Unsigned byte load at 0x0D → 0x000000F0.
  - Signed halfword load at 0x0E → 0x00007F01.
- Misaligned: halfword load at 0x05 → done=1 and err=1 at N+1, no mem_we, rdata unchanged. Word store at 0x06 behaves the same.
- Busy and latency sweep:
  - A second req held high during WAIT is ignored; exactly one done occurs.
  - Repeat the load and sub-word store cases with RD_LAT=1 and RD_LAT=3 → done at N+3/N+4 and N+5/N+6 respectively.
